// File: rtl/structure_tensor_accum_if.sv
// Gradient-in / tensor-sum-out bundle between gradient_compute, the tensor accumulator and the flow solver.
// Instantiate with the same GRAD_WIDTH/ACC_WIDTH as the accumulator that uses it.
interface structure_tensor_accum_if #(
   parameter int GRAD_WIDTH = 12,
   parameter int ACC_WIDTH  = 30
);
   logic signed [GRAD_WIDTH-1:0] grad_x;
   logic signed [GRAD_WIDTH-1:0] grad_y;
   logic signed [GRAD_WIDTH-1:0] grad_t;
   logic                         grad_valid;
   logic signed [ACC_WIDTH-1:0]  sum_ixx;
   logic signed [ACC_WIDTH-1:0]  sum_iyy;
   logic signed [ACC_WIDTH-1:0]  sum_ixy;
   logic signed [ACC_WIDTH-1:0]  sum_ixt;
   logic signed [ACC_WIDTH-1:0]  sum_iyt;
   logic                         sum_valid;
   logic                         frame_done;

   modport master (
      output grad_x, grad_y, grad_t, grad_valid,
      input  sum_ixx, sum_iyy, sum_ixy, sum_ixt, sum_iyt, sum_valid, frame_done
   );

   modport slave (
      input  grad_x, grad_y, grad_t, grad_valid,
      output sum_ixx, sum_iyy, sum_ixy, sum_ixt, sum_iyt, sum_valid, frame_done
   );
endinterface

// File: rtl/structure_tensor_accum.sv
// Lucas-Kanade structure tensor: per-pixel gradient products box-summed over a WIN x WIN window.
// Three stages (product, column sum, row sum); one result per fully-interior window.
module structure_tensor_accum #(
   parameter int GRAD_WIDTH = 12,
   parameter int IMG_WIDTH  = 320,
   parameter int IMG_HEIGHT = 240,
   parameter int WIN        = 5,
   parameter int ACC_WIDTH  = 30
) (
   input logic                     clk,
   input logic                     rst_n,
   structure_tensor_accum_if.slave bus
);
   localparam int PW = 2 * GRAD_WIDTH;
   localparam int XW = $clog2(IMG_WIDTH);
   localparam int YW = $clog2(IMG_HEIGHT);
   localparam int RW = $clog2(WIN);
   localparam int NP = 5;

   localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);
   localparam logic [RW-1:0] R_LAST = RW'(WIN - 1);
   localparam logic [XW-1:0] X_WIN  = XW'(WIN);
   localparam logic [XW-1:0] X_EDGE = XW'(WIN - 1);
   localparam logic [YW-1:0] Y_WIN  = YW'(WIN);
   localparam logic [YW-1:0] Y_EDGE = YW'(WIN - 1);

   generate
      if (ACC_WIDTH < 2 * GRAD_WIDTH + $clog2(WIN * WIN)) begin : g_acc_too_narrow
         $error("structure_tensor_accum: ACC_WIDTH too narrow for a WIN x WIN sum of products");
      end
      if (WIN < 3 || (WIN % 2) == 0) begin : g_bad_win
         $error("structure_tensor_accum: WIN must be odd and >= 3");
      end
   endgenerate

   // Raster position of the next accepted pixel; r_cnt is y modulo WIN and picks the ring row.
   logic [XW-1:0] x_cnt;
   logic [YW-1:0] y_cnt;
   logic [RW-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         x_cnt <= '0;
         y_cnt <= '0;
         r_cnt <= '0;
      end else if (bus.grad_valid) begin
         if (x_cnt == X_LAST) begin
            x_cnt <= '0;
            if (y_cnt == Y_LAST) begin
               y_cnt <= '0;
               r_cnt <= '0;
            end else begin
               y_cnt <= y_cnt + 1'b1;
               r_cnt <= (r_cnt == R_LAST) ? '0 : r_cnt + 1'b1;
            end
         end else begin
            x_cnt <= x_cnt + 1'b1;
         end
      end
   end

   logic signed [PW-1:0] gx_e;
   logic signed [PW-1:0] gy_e;
   logic signed [PW-1:0] gt_e;

   assign gx_e = PW'(bus.grad_x);
   assign gy_e = PW'(bus.grad_y);
   assign gt_e = PW'(bus.grad_t);

   // Product order everywhere: ixx, iyy, ixy, ixt, iyt.
   logic                 v1;
   logic signed [PW-1:0] prod [NP];
   logic [XW-1:0]        x1;
   logic [YW-1:0]        y1;
   logic [RW-1:0]        r1;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         v1 <= 1'b0;
      end else begin
         v1 <= bus.grad_valid;
      end
   end

   always_ff @(posedge clk) begin
      if (bus.grad_valid) begin
         prod[0] <= gx_e * gx_e;
         prod[1] <= gy_e * gy_e;
         prod[2] <= gx_e * gy_e;
         prod[3] <= gx_e * gt_e;
         prod[4] <= gy_e * gt_e;
         x1      <= x_cnt;
         y1      <= y_cnt;
         r1      <= r_cnt;
      end
   end

   // Column sums over the last WIN rows. The ring slot at r1 still holds the product from WIN rows up.
   logic signed [ACC_WIDTH-1:0] colsum_mem [NP][IMG_WIDTH];
   logic signed [PW-1:0]        ring_mem   [NP][WIN][IMG_WIDTH];
   logic signed [ACC_WIDTH-1:0] col_calc   [NP];

   always_comb begin
      for (int k = 0; k < NP; k++) begin
         col_calc[k] = ACC_WIDTH'(prod[k]);
         if (y1 != '0) begin
            col_calc[k] = col_calc[k] + colsum_mem[k][x1];
         end
         if (y1 >= Y_WIN) begin
            col_calc[k] = col_calc[k] - ACC_WIDTH'(ring_mem[k][r1][x1]);
         end
      end
   end

   logic                        v2;
   logic signed [ACC_WIDTH-1:0] col2 [NP];
   logic [XW-1:0]               x2;
   logic [YW-1:0]               y2;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         v2 <= 1'b0;
      end else begin
         v2 <= v1;
      end
   end

   always_ff @(posedge clk) begin
      if (v1) begin
         for (int k = 0; k < NP; k++) begin
            colsum_mem[k][x1]   <= col_calc[k];
            ring_mem[k][r1][x1] <= prod[k];
            col2[k]             <= col_calc[k];
         end
         x2 <= x1;
         y2 <= y1;
      end
   end

   // Row sum: running total of the last WIN column sums, oldest one taken from the shift register.
   logic signed [ACC_WIDTH-1:0] col_sr   [NP][WIN];
   logic signed [ACC_WIDTH-1:0] rowsum   [NP];
   logic signed [ACC_WIDTH-1:0] row_calc [NP];
   logic                        interior;

   assign interior = (x2 >= X_EDGE) && (y2 >= Y_EDGE);

   always_comb begin
      for (int k = 0; k < NP; k++) begin
         row_calc[k] = col2[k];
         if (x2 != '0) begin
            row_calc[k] = row_calc[k] + rowsum[k];
         end
         if (x2 >= X_WIN) begin
            row_calc[k] = row_calc[k] - col_sr[k][WIN-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (v2) begin
         for (int k = 0; k < NP; k++) begin
            rowsum[k]    <= row_calc[k];
            col_sr[k][0] <= col2[k];
            for (int j = 1; j < WIN; j++) begin
               col_sr[k][j] <= col_sr[k][j-1];
            end
         end
      end
   end

   logic signed [ACC_WIDTH-1:0] sum_r [NP];
   logic                        sum_valid_r;
   logic                        frame_done_r;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sum_valid_r  <= 1'b0;
         frame_done_r <= 1'b0;
         for (int k = 0; k < NP; k++) begin
            sum_r[k] <= '0;
         end
      end else begin
         sum_valid_r  <= v2 && interior;
         frame_done_r <= v2 && (x2 == X_LAST) && (y2 == Y_LAST);
         if (v2 && interior) begin
            for (int k = 0; k < NP; k++) begin
               sum_r[k] <= row_calc[k];
            end
         end
      end
   end

   assign bus.sum_ixx    = sum_r[0];
   assign bus.sum_iyy    = sum_r[1];
   assign bus.sum_ixy    = sum_r[2];
   assign bus.sum_ixt    = sum_r[3];
   assign bus.sum_iyt    = sum_r[4];
   assign bus.sum_valid  = sum_valid_r;
   assign bus.frame_done = frame_done_r;

endmodule

// File: tb/tb_structure_tensor_accum.sv
// Directed bench for structure_tensor_accum on a 16x12 frame with a 5x5 window.
// Expected sums come from a brute-force window sum over the stored frame plus hand-computed constants.
module tb_structure_tensor_accum;
   localparam int GW = 12;
   localparam int W  = 16;
   localparam int H  = 12;
   localparam int WN = 5;
   localparam int AW = 30;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   structure_tensor_accum_if #(.GRAD_WIDTH(GW), .ACC_WIDTH(AW)) bus ();

   structure_tensor_accum #(
      .GRAD_WIDTH(GW), .IMG_WIDTH(W), .IMG_HEIGHT(H), .WIN(WN), .ACC_WIDTH(AW)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      int     cyc;
      longint ixx, iyy, ixy, ixt, iyt;
      bit     fd;
   } exp_t;

   exp_t   expQ[$];
   int     fx [H][W];
   int     fy [H][W];
   int     ft [H][W];
   int     cyc = 0;
   int     vecCount = 0;
   int     errCount = 0;
   int     resultCount = 0;
   int     fdCount = 0;
   int     nzCount = 0;
   longint lastIxx = 0;
   longint lastIyt = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string tag, input longint observed, input longint expected);
      vecCount++;
      if (observed !== expected) begin
         errCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, observed, expected, cyc);
      end
   endtask

   function automatic longint prodOf(input int which, input int px, input int py);
      longint a, b;
      case (which)
         0:       begin a = fx[py][px]; b = fx[py][px]; end
         1:       begin a = fy[py][px]; b = fy[py][px]; end
         2:       begin a = fx[py][px]; b = fy[py][px]; end
         3:       begin a = fx[py][px]; b = ft[py][px]; end
         default: begin a = fy[py][px]; b = ft[py][px]; end
      endcase
      return a * b;
   endfunction

   function automatic longint winSum(input int which, input int px, input int py);
      longint s = 0;
      for (int i = 0; i < WN; i++)
         for (int j = 0; j < WN; j++)
            s += prodOf(which, px - j, py - i);
      return s;
   endfunction

   // mode 0: constant (a,b,c); mode 1: gx=3 impulse at (7,5); mode 2: ramp plus random noise.
   task automatic fillFrame(input int mode, input int a, input int b, input int c);
      for (int y = 0; y < H; y++) begin
         for (int x = 0; x < W; x++) begin
            case (mode)
               0: begin fx[y][x] = a; fy[y][x] = b; ft[y][x] = c; end
               1: begin fx[y][x] = (x == 7 && y == 5) ? 3 : 0; fy[y][x] = 0; ft[y][x] = 0; end
               default: begin
                  fx[y][x] = x * 100 - 800 + int'($urandom_range(0, 400)) - 200;
                  fy[y][x] = y * 150 - 900 + int'($urandom_range(0, 400)) - 200;
                  ft[y][x] = int'($urandom_range(0, 4095)) - 2048;
               end
            endcase
         end
      end
   endtask

   // Drives pixels 0..stopIdx-1 in raster order, leaving grad_valid high on the last beat.
   task automatic applyStimulus(input int gapPct, input int stopIdx);
      for (int idx = 0; idx < W * H && idx < stopIdx; idx++) begin
         int px, py;
         exp_t e;
         px = idx % W;
         py = idx / W;
         while (int'($urandom_range(0, 99)) < gapPct) begin
            @(posedge clk); #1;
            bus.grad_valid = 1'b0;
         end
         @(posedge clk); #1;
         bus.grad_x     = GW'(fx[py][px]);
         bus.grad_y     = GW'(fy[py][px]);
         bus.grad_t     = GW'(ft[py][px]);
         bus.grad_valid = 1'b1;
         if (px >= WN - 1 && py >= WN - 1) begin
            e.cyc = cyc;
            e.ixx = winSum(0, px, py);
            e.iyy = winSum(1, px, py);
            e.ixy = winSum(2, px, py);
            e.ixt = winSum(3, px, py);
            e.iyt = winSum(4, px, py);
            e.fd  = (px == W - 1 && py == H - 1);
            expQ.push_back(e);
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         bus.grad_valid = 1'b0;
      end
   endtask

   task automatic clearCounts();
      resultCount = 0;
      fdCount     = 0;
      nzCount     = 0;
   endtask

   task automatic endFrames(input string tag, input int expResults, input int expFd);
      idle(6);
      checkOutput({tag, "_results"}, resultCount, expResults);
      checkOutput({tag, "_frame_done"}, fdCount, expFd);
      checkOutput({tag, "_pending"}, expQ.size(), 0);
   endtask

   task automatic handCheck(input string tag, input longint a, input longint b, input longint c,
                            input longint d, input longint e);
      checkOutput({tag, "_ixx"}, bus.sum_ixx, a);
      checkOutput({tag, "_iyy"}, bus.sum_iyy, b);
      checkOutput({tag, "_ixy"}, bus.sum_ixy, c);
      checkOutput({tag, "_ixt"}, bus.sum_ixt, d);
      checkOutput({tag, "_iyt"}, bus.sum_iyt, e);
   endtask

   // Scoreboard: every result is matched in order against the model queue, including its arrival cycle.
   always @(negedge clk) begin
      if (bus.sum_valid === 1'b1) begin
         resultCount++;
         if (bus.frame_done === 1'b1) fdCount++;
         if (bus.sum_ixx != 0) nzCount++;
         if (expQ.size() == 0) begin
            checkOutput("spurious_valid", 1, 0);
         end else begin
            exp_t e;
            e = expQ.pop_front();
            checkOutput("latency", cyc, e.cyc + 3);
            checkOutput("ixx", bus.sum_ixx, e.ixx);
            checkOutput("iyy", bus.sum_iyy, e.iyy);
            checkOutput("ixy", bus.sum_ixy, e.ixy);
            checkOutput("ixt", bus.sum_ixt, e.ixt);
            checkOutput("iyt", bus.sum_iyt, e.iyt);
            checkOutput("frame_done", bus.frame_done, e.fd);
         end
         lastIxx = bus.sum_ixx;
         lastIyt = bus.sum_iyt;
      end else begin
         checkOutput("idle_frame_done", bus.frame_done, 0);
         checkOutput("hold_ixx", bus.sum_ixx, lastIxx);
         checkOutput("hold_iyt", bus.sum_iyt, lastIyt);
      end
      if (rst_n === 1'b0) begin
         expQ.delete();
         lastIxx = 0;
         lastIyt = 0;
      end
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      bus.grad_x     = '0;
      bus.grad_y     = '0;
      bus.grad_t     = '0;
      bus.grad_valid = 1'b0;
      rst_n          = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_sum_valid", bus.sum_valid, 0);
      checkOutput("rst_frame_done", bus.frame_done, 0);
      handCheck("rst", 0, 0, 0, 0, 0);
      rst_n = 1'b1;

      $display("[TB] constant frame");
      fillFrame(0, 1, 2, -1);
      clearCounts();
      applyStimulus(0, W * H);
      endFrames("const", 96, 1);
      handCheck("const", 25, 100, 50, -25, -50);

      $display("[TB] impulse frame");
      fillFrame(1, 0, 0, 0);
      clearCounts();
      applyStimulus(0, W * H);
      endFrames("impulse", 96, 1);
      checkOutput("impulse_nonzero", nzCount, 25);
      handCheck("impulse_last", 0, 0, 0, 0, 0);

      $display("[TB] extreme frame");
      fillFrame(0, -2048, 2047, -2048);
      clearCounts();
      applyStimulus(0, W * H);
      endFrames("extreme", 96, 1);
      handCheck("extreme", 104857600, 104755225, -104806400, 104857600, -104806400);

      $display("[TB] gapped constant and random frames");
      fillFrame(0, 1, 2, -1);
      clearCounts();
      applyStimulus(50, W * H);
      endFrames("gap_const", 96, 1);
      handCheck("gap_const", 25, 100, 50, -25, -50);
      fillFrame(2, 0, 0, 0);
      clearCounts();
      applyStimulus(50, W * H);
      endFrames("gap_random", 96, 1);

      $display("[TB] reset mid-frame");
      fillFrame(0, 1, 2, -1);
      applyStimulus(0, 6 * W + 9);
      @(posedge clk); #1;
      bus.grad_valid = 1'b0;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      checkOutput("midrst_sum_valid", bus.sum_valid, 0);
      handCheck("midrst", 0, 0, 0, 0, 0);
      clearCounts();
      idle(6);
      checkOutput("midrst_no_results", resultCount, 0);
      applyStimulus(0, W * H);
      endFrames("after_rst", 96, 1);
      handCheck("after_rst", 25, 100, 50, -25, -50);

      $display("[TB] back-to-back frames");
      fillFrame(0, 1, 2, -1);
      clearCounts();
      applyStimulus(0, W * H);
      fillFrame(0, -3, 1, 2);
      applyStimulus(0, W * H);
      endFrames("b2b", 192, 2);
      handCheck("b2b_frame2", 225, 25, -75, -150, 50);

      $display("[TB] == %0d vectors applied, %0d miscompares ==", vecCount, errCount);
      $finish;
   end

endmodule
